// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline controller slice.
//   REG_ADDR_W : architectural register address width
//   state_t    : controller FSM states (RUN, MEM_WAIT, ERR)
package pipe_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use hazard compare.
// Ports:
//   id_rs1, id_rs2           : sources of the instruction in ID
//   id_uses_rs1, id_uses_rs2 : ID instruction actually reads that source
//   ex_rd, ex_is_load        : destination / load flag of the EX instruction
//   load_use                 : ID must wait one cycle for the EX load result
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_is_load,
  output logic                  load_use
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
    rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
    // x0 is hardwired to zero, so a load targeting it never creates a dependency
    load_use = ex_is_load && (ex_rd != '0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush controller.
// Ports:
//   clk, rst_n                : clock, asynchronous active-low reset
//   id_rs1/id_rs2/id_uses_*   : ID-stage source operands
//   ex_rd/ex_is_load          : EX-stage destination and load flag
//   ex_branch_taken           : EX redirects the PC
//   mem_req/mem_ready         : MEM-stage access handshake
//   *_en / *_flush            : stage-register load enables and bubble inserts
//   mem_err                   : sticky memory-timeout error
//   stall_cnt                 : saturating count of cycles with if_id_en=0
// Priority per cycle: memory wait > branch flush > load-use stall.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_is_load,
  input  logic                  ex_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  ex_mem_en,
  output logic                  mem_wb_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  mem_wb_flush,
  output logic                  mem_err,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  // Value of the wait counter during the last permitted MEM_WAIT cycle
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              load_use;
  logic              mem_stall;
  logic [6:0]        ctl;  // {if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, mem_wb_flush}

  hazard_detect u_hazard (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_rd       (ex_rd),
    .ex_is_load  (ex_is_load),
    .load_use    (load_use)
  );

  // Mealy output decode. A branch held in EX during a memory stall is
  // naturally honoured on release because EX stays frozen until then.
  always_comb begin
    mem_stall = 1'b0;
    ctl       = '0;
    case (state)
      RUN, MEM_WAIT: begin
        mem_stall = (state == MEM_WAIT) ? !mem_ready : (mem_req && !mem_ready);
        if (mem_stall)            ctl = 7'b0000_001;
        else if (ex_branch_taken) ctl = 7'b1111_110;
        else if (load_use)        ctl = 7'b0111_010;
        else                      ctl = 7'b1111_000;
      end
      default: ctl = '0;
    endcase
  end

  // Reset forces every enable/flush low without waiting for a clock edge
  always_comb begin
    {if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
     if_id_flush, id_ex_flush, mem_wb_flush} = rst_n ? ctl : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (mem_stall) begin
            state    <= MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt >= WAIT_LAST) begin
            state   <= ERR;
            mem_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        ERR: begin
          mem_err <= 1'b1;
        end
        default: begin
          state <= RUN;
        end
      endcase

      if ((state != ERR) && !ctl[6] && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl. A reference model predicts outputs when
// stimulus is driven; predictions are queued and compared when sampled.
module tb_pipe_ctrl;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic        id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
  logic        ex_is_load = 1'b0, ex_branch_taken = 1'b0;
  logic        mem_req = 1'b0, mem_ready = 1'b0;

  logic        if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_flush, mem_wb_flush, mem_err;
  logic [31:0] stall_cnt;
  logic        s_if_id_en, s_id_ex_en, s_ex_mem_en, s_mem_wb_en;
  logic        s_if_id_flush, s_id_ex_flush, s_mem_wb_flush, s_mem_err;
  logic [2:0]  s_stall_cnt;
  logic [6:0]  ctl;

  always #5 clk = ~clk;

  pipe_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .mem_wb_flush(mem_wb_flush),
    .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  pipe_ctrl #(.CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .if_id_en(s_if_id_en), .id_ex_en(s_id_ex_en), .ex_mem_en(s_ex_mem_en), .mem_wb_en(s_mem_wb_en),
    .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush), .mem_wb_flush(s_mem_wb_flush),
    .mem_err(s_mem_err), .stall_cnt(s_stall_cnt)
  );

  assign ctl = {if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, mem_wb_flush};

  typedef struct {
    logic [6:0]  ctl;
    logic        err;
    logic [31:0] cnt;
    bit          sat_chk;
    logic [2:0]  sat;
  } exp_t;

  exp_t sb[$];

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  // model state: 0=RUN 1=MEM_WAIT 2=ERR
  int          m_state = 0;
  int          m_wait = 0;
  bit          m_err = 1'b0;
  int unsigned m_cnt = 0;
  int unsigned m_cnt3 = 0;
  bit          chk_sat = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [6:0] model_ctl();
    bit ms, lu;
    if (m_state == 2) return 7'b0000_000;
    ms = (m_state == 1) ? !mem_ready : (mem_req && !mem_ready);
    lu = ex_is_load && (ex_rd != 5'd0) &&
         ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));
    if (ms)              return 7'b0000_001;
    if (ex_branch_taken) return 7'b1111_110;
    if (lu)              return 7'b0111_010;
    return 7'b1111_000;
  endfunction

  task automatic step(input string name, input logic r, input logic mreq, input logic mrdy,
                      input logic br, input logic ld, input logic [4:0] rd,
                      input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2);
    exp_t e, got;
    @(negedge clk);
    rst_n = r; mem_req = mreq; mem_ready = mrdy; ex_branch_taken = br;
    ex_is_load = ld; ex_rd = rd; id_rs1 = r1; id_uses_rs1 = u1; id_rs2 = r2; id_uses_rs2 = u2;
    if (!r) begin
      m_state = 0; m_wait = 0; m_err = 1'b0; m_cnt = 0; m_cnt3 = 0;
    end
    e.ctl = r ? model_ctl() : 7'b0;
    e.err = m_err;
    e.cnt = m_cnt;
    e.sat_chk = chk_sat;
    e.sat = 3'(m_cnt3);
    sb.push_back(e);
    #2;
    got = sb.pop_front();
    check({name, "/ctl"}, {25'b0, ctl}, {25'b0, got.ctl});
    check({name, "/err"}, {31'b0, mem_err}, {31'b0, got.err});
    check({name, "/cnt"}, stall_cnt, got.cnt);
    if (got.sat_chk) check({name, "/sat"}, {29'b0, s_stall_cnt}, {29'b0, got.sat});
    @(posedge clk);
    if (r) begin
      if (m_state != 2 && !got.ctl[6]) begin
        if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
        if (m_cnt3 < 7) m_cnt3++;
      end
      case (m_state)
        0: if (mreq && !mrdy) begin m_state = 1; m_wait = 0; end
        1: begin
          if (mrdy) begin m_state = 0; m_wait = 0; end
          else if (m_wait + 1 == TO) begin m_state = 2; m_err = 1'b1; end
          else m_wait++;
        end
        default: ;
      endcase
    end
  endtask

  task automatic idle(input string name);
    step(name, 1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
  endtask

  task automatic do_reset();
    step("rst", 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    step("rst", 0, 1, 0, 1, 1, 5'd5, 5'd5, 1, 5'd5, 1);
  endtask

  initial begin
    do_reset();
    idle("first");

    // saturation on the 3-bit counter instance
    chk_sat = 1'b1;
    for (int i = 0; i < 10; i++) step("sat_lu", 1, 0, 0, 0, 1, 5'd7, 5'd7, 1, 5'd0, 0);
    idle("sat_end");
    chk_sat = 1'b0;

    // load-use variants
    do_reset();
    step("lu_rs1", 1, 0, 0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0);
    idle("lu_after");
    step("lu_rd0", 1, 0, 0, 0, 1, 5'd0, 5'd0, 1, 5'd0, 1);
    step("lu_rs2", 1, 0, 0, 0, 1, 5'd9, 5'd1, 1, 5'd9, 1);
    step("lu_rs2_unused", 1, 0, 0, 0, 1, 5'd9, 5'd1, 1, 5'd9, 0);
    step("lu_rs1_unused", 1, 0, 0, 0, 1, 5'd5, 5'd5, 0, 5'd0, 0);
    step("lu_not_load", 1, 0, 0, 0, 0, 5'd5, 5'd5, 1, 5'd5, 1);
    step("branch", 1, 0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    step("mem_ready_hit", 1, 1, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);

    // memory wait: three stalled cycles then release
    do_reset();
    for (int i = 0; i < 3; i++) step("mwait", 1, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    step("mwait_rel", 1, 1, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    idle("mwait_run");

    // branch + load-use + memory stall together
    do_reset();
    for (int i = 0; i < 2; i++) step("simul", 1, 1, 0, 1, 1, 5'd3, 5'd3, 1, 5'd0, 0);
    step("simul_rel", 1, 1, 1, 1, 1, 5'd3, 5'd3, 1, 5'd0, 0);
    idle("simul_run");

    // timeout into the sticky error state
    do_reset();
    for (int i = 0; i < 7; i++) step("tmo", 1, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    step("err_hold", 1, 1, 1, 1, 1, 5'd2, 5'd2, 1, 5'd0, 0);
    step("err_rst", 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    idle("err_run");

    // asynchronous reset between edges while in MEM_WAIT
    for (int i = 0; i < 2; i++) step("pre_arst", 1, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    step("arst", 0, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    idle("arst_run");
    idle("arst_run2");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255: maximum consecutive MEM_WAIT cycles before the error state.
REQ-002 Parameter CNT_W, default 32: stall-counter width.
REQ-003 clk  in  1  pipeline clock; all state changes on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
REQ-006 id_uses_rs1, id_uses_rs2  in  1 each  the ID instruction reads that source.
REQ-007 ex_rd  in  5  destination of the instruction in EX.
REQ-008 ex_is_load  in  1  the EX instruction is a load.
REQ-009 ex_branch_taken  in  1  the EX instruction redirects the PC.
REQ-010 mem_req  in  1  the MEM stage holds a load/store access.
REQ-011 mem_ready  in  1  data memory completes the access this cycle.
REQ-012 if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  stage-register load enables.
REQ-013 if_id_flush, id_ex_flush, mem_wb_flush  out  1 each  load a bubble (NOP, rd=0) into that register.
REQ-014 mem_err  out  1  sticky memory-timeout error.
REQ-015 stall_cnt  out  CNT_W  count of cycles with if_id_en=0.

Function
REQ-016 FSM states: RUN, MEM_WAIT, ERR; stage-register outputs are Mealy (current state plus current inputs).
REQ-017 Priority within one cycle: memory wait > branch flush > load-use stall.
REQ-018 Memory stall in RUN: mem_req=1 and mem_ready=0 -> all four enables 0, mem_wb_flush=1, next state MEM_WAIT.
REQ-019 In MEM_WAIT with mem_ready=0: same outputs as REQ-018; the wait counter increments.
REQ-020 In MEM_WAIT with mem_ready=1: evaluate as RUN in the same cycle (branch/load-use rules apply); next state RUN; wait counter cleared.
REQ-021 Wait counter reaching MEM_TIMEOUT in MEM_WAIT -> next state ERR; mem_err=1 from the following cycle.
REQ-022 ERR: all enables 0, all flushes 0, mem_err=1; only reset exits ERR.
REQ-023 Branch, no memory stall: ex_branch_taken=1 -> if_id_flush=1, id_ex_flush=1, all enables 1.
REQ-024 Load-use, no memory stall, no branch: ex_is_load=1, ex_rd!=0, and (id_uses_rs1 and id_rs1==ex_rd, or id_uses_rs2 and id_rs2==ex_rd) -> if_id_en=0, id_ex_flush=1, ex_mem_en=1, mem_wb_en=1.
REQ-025 ex_rd=0 never causes a load-use stall.
REQ-026 No hazard: all enables 1, all flushes 0.
REQ-027 A branch present in EX during a memory stall is held (EX is frozen) and takes effect in the cycle the stall releases.
REQ-028 stall_cnt increments by 1 in every cycle with if_id_en=0 while not in ERR, and saturates at all-ones.

Reset
REQ-029 While rst_n=0: state=RUN, wait counter=0, mem_err=0, stall_cnt=0; all enables and flushes are forced to 0.
REQ-030 Reset asserted in MEM_WAIT or ERR returns the block to RUN immediately, asynchronously, without waiting for mem_ready.
REQ-031 First edge after rst_n rises: normal RUN evaluation.

Structure
REQ-032 Package pipe_pkg holds the state enum (RUN, MEM_WAIT, ERR) and REG_ADDR_W=5.
REQ-033 Load-use compare lives in a combinational sub-module hazard_detect; the FSM, counters and output muxing live in pipe_ctrl.

Verification
REQ-034 Load-use: ex_is_load=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> if_id_en=0, id_ex_flush=1, stall_cnt +1; with ex_rd=0 -> no stall.
REQ-035 Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 -> enables 0 and mem_wb_flush=1 for 3 cycles, enables 1 on the 4th, state RUN, stall_cnt=3.
REQ-036 Simultaneous: branch taken plus load-use plus mem stall -> freeze only; on release -> if_id_flush=id_ex_flush=1, no load-use stall.
REQ-037 Timeout: MEM_TIMEOUT=4, mem_ready held 0 -> ERR after 4 wait cycles, mem_err=1 sticky; rst_n pulse -> RUN, mem_err=0.
REQ-038 Saturation: CNT_W=3, 10 stall cycles -> stall_cnt=7.
REQ-039 Asynchronous reset mid-MEM_WAIT (between clock edges) -> outputs 0 and state RUN immediately, with no clock edge.
